// File: rtl/dmem_responder_pkg.sv
// Shared encodings and helpers for the data-memory responder.
// The size and state encodings match the core's load/store control decode.
package dmem_responder_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  function automatic logic access_error(input logic [1:0]  size,
                                        input logic [31:0] addr,
                                        input logic [32:0] limit);
    logic e;
    case (size)
      SZ_B:    e = 1'b0;
      SZ_H:    e = addr[0];
      SZ_W:    e = |addr[1:0];
      default: e = 1'b1;
    endcase
    return e | ({1'b0, addr} >= limit);
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] size,
                                             input logic [1:0] lo);
    case (size)
      SZ_B:    return 4'b0001 << lo;
      SZ_H:    return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_load_extend.sv
// Selects the addressed lane of a memory word and sign- or zero-extends it
// to 32 bits, ready for the write-back path.
module dmem_responder_load_extend
  import dmem_responder_pkg::*;
(
  input  logic [31:0] rdword,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = 8'h00;
    case (addr_lo)
      2'd0: lane_b = rdword[7:0];
      2'd1: lane_b = rdword[15:8];
      2'd2: lane_b = rdword[23:16];
      2'd3: lane_b = rdword[31:24];
      default: lane_b = 8'h00;
    endcase
    lane_h = addr_lo[1] ? rdword[31:16] : rdword[15:0];

    case (size)
      SZ_B:    result = is_unsigned ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_H:    result = is_unsigned ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: result = rdword;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, fixed
// response latency, byte/half/word access with error flagging.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT = 33'(4 * DEPTH_WORDS);

  state_t      state;
  logic [3:0]  cnt;
  req_t        held;
  req_t        cur;
  logic        accept;
  logic        enter_resp;
  logic        err;
  logic [AW-1:0] idx;
  logic [31:0] rd_word;
  logic [31:0] ext_data;
  logic [31:0] wr_data;
  logic [31:0] merged;
  logic [3:0]  be;
  logic [31:0] mem [DEPTH_WORDS];

  assign accept = req_valid & req_ready;

  // In IDLE the live inputs are the request (needed when LATENCY=1 enters
  // RESP on the accept edge); afterwards only the captured copy is used.
  always_comb begin
    cur = held;
    if (state == ST_IDLE) begin
      cur.we    = req_we;
      cur.size  = req_size;
      cur.uns   = req_unsigned;
      cur.addr  = req_addr;
      cur.wdata = req_wdata;
    end
  end

  assign enter_resp = rst_n &&
                      (((state == ST_IDLE) && accept && (LATENCY == 1)) ||
                       ((state == ST_WAIT) && (cnt == 4'd1)));

  assign err     = access_error(cur.size, cur.addr, LIMIT);
  assign idx     = cur.addr[AW+1:2];
  assign rd_word = mem[idx];
  assign be      = byte_enable(cur.size, cur.addr[1:0]);

  always_comb begin
    case (cur.size)
      SZ_B:    wr_data = {4{cur.wdata[7:0]}};
      SZ_H:    wr_data = {2{cur.wdata[15:0]}};
      default: wr_data = cur.wdata;
    endcase
    merged = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  dmem_responder_load_extend u_load_extend (
    .rdword      (rd_word),
    .addr_lo     (cur.addr[1:0]),
    .size        (cur.size),
    .is_unsigned (cur.uns),
    .result      (ext_data)
  );

  // The array has no reset so it can map onto a RAM and survive rst_n.
  always_ff @(posedge clk) begin
    if (enter_resp && cur.we && !err) mem[idx] <= merged;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      held      <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            held      <= cur;
            req_ready <= 1'b0;
            cnt       <= 4'(LATENCY - 1);
            state     <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ST_RESP;
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase

      if (enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_err   <= err;
        rsp_rdata <= (err || cur.we) ? 32'h0 : ext_data;
      end else begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance and a LATENCY=1
// instance share the request bus; 'sel' picks which one is being exercised.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        sel = 1'b0;

  logic        ready2, valid2, err2, ready1, valid1, err1;
  logic [31:0] rdata2, rdata1;

  logic        ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~sel), .req_ready(ready2),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(valid2), .rsp_rdata(rdata2), .rsp_err(err2));

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & sel), .req_ready(ready1),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(valid1), .rsp_rdata(rdata1), .rsp_err(err1));

  assign ready     = sel ? ready1 : ready2;
  assign rsp_valid = sel ? valid1 : valid2;
  assign rsp_rdata = sel ? rdata1 : rdata2;
  assign rsp_err   = sel ? err1   : err2;

  function automatic int cur_lat();
    return sel ? 1 : 2;
  endfunction

  // Issues one request and returns the response plus the number of negedges
  // from the accept edge to the first one showing rsp_valid (0 = timeout).
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic e, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    lat = 0; rd = 32'hxxxxxxxx; e = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) req_valid = 1'b0;
      if (rsp_valid) begin
        lat = n; rd = rsp_rdata; e = rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (ready2 !== 1'b1 || ready1 !== 1'b1) begin
      fails++; $display("[TB] FAIL reset_ready: got %b/%b want 1/1", ready2, ready1);
    end
    tests++;
    if (valid2 !== 1'b0 || valid1 !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_valid: got %b/%b want 0/0", valid2, valid1);
    end
    tests++;
    if (rdata2 !== 32'h0 || err2 !== 1'b0 || rdata1 !== 32'h0 || err1 !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_rsp: got %h,%b/%h,%b want 0", rdata2, err2, rdata1, err1);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic e; int lat;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, e, lat);
    tests++;
    if (lat !== cur_lat() || e !== 1'b0 || rd !== 32'h0) begin
      fails++; $display("[TB] FAIL sw_10 sel=%0b: lat=%0d err=%b rd=%h want lat=%0d err=0 rd=0", sel, lat, e, rd, cur_lat());
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, e, lat);
    tests++;
    if (lat !== cur_lat() || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
      fails++; $display("[TB] FAIL lw_10 sel=%0b: lat=%0d err=%b rd=%h want lat=%0d err=0 rd=deadbeef", sel, lat, e, rd, cur_lat());
    end
  endtask

  task automatic test_byte_store();
    logic [31:0] rd; logic e; int lat;
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hAAAAAA7F, rd, e, lat);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, e, lat);
    tests++;
    if (rd !== 32'hDEAD7FEF || e !== 1'b0 || lat !== cur_lat()) begin
      fails++; $display("[TB] FAIL sb_merge sel=%0b: rd=%h err=%b lat=%0d want dead7fef 0 %0d", sel, rd, e, lat, cur_lat());
    end
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd, e, lat);
    tests++;
    if (rd !== 32'hFFFFFFDE || e !== 1'b0) begin
      fails++; $display("[TB] FAIL lb_13 sel=%0b: rd=%h err=%b want ffffffde 0", sel, rd, e);
    end
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, e, lat);
    tests++;
    if (rd !== 32'h000000DE || e !== 1'b0) begin
      fails++; $display("[TB] FAIL lbu_13 sel=%0b: rd=%h err=%b want 000000de 0", sel, rd, e);
    end
  endtask

  task automatic test_half_load();
    logic [31:0] rd; logic e; int lat;
    do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h80011234, rd, e, lat);
    do_req(1'b0, 2'b01, 1'b0, 32'h42, 32'h0, rd, e, lat);
    tests++;
    if (rd !== 32'hFFFF8001 || e !== 1'b0) begin
      fails++; $display("[TB] FAIL lh_42: rd=%h err=%b want ffff8001 0", rd, e);
    end
    do_req(1'b0, 2'b01, 1'b1, 32'h42, 32'h0, rd, e, lat);
    tests++;
    if (rd !== 32'h00008001 || e !== 1'b0) begin
      fails++; $display("[TB] FAIL lhu_42: rd=%h err=%b want 00008001 0", rd, e);
    end
    do_req(1'b0, 2'b01, 1'b0, 32'h40, 32'h0, rd, e, lat);
    tests++;
    if (rd !== 32'h00001234 || e !== 1'b0) begin
      fails++; $display("[TB] FAIL lh_40: rd=%h err=%b want 00001234 0", rd, e);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic e; int lat;
    do_req(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, rd, e, lat);
    tests++;
    if (e !== 1'b1 || rd !== 32'h0 || lat !== cur_lat()) begin
      fails++; $display("[TB] FAIL lw_misaligned: err=%b rd=%h lat=%0d want 1 0 %0d", e, rd, lat, cur_lat());
    end
    do_req(1'b1, 2'b01, 1'b0, 32'h13, 32'h0000FFFF, rd, e, lat);
    tests++;
    if (e !== 1'b1 || rd !== 32'h0) begin
      fails++; $display("[TB] FAIL sh_misaligned: err=%b rd=%h want 1 0", e, rd);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, e, lat);
    tests++;
    if (rd !== 32'hDEAD7FEF || e !== 1'b0) begin
      fails++; $display("[TB] FAIL sh_no_write: rd=%h err=%b want dead7fef 0", rd, e);
    end
    do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, rd, e, lat);
    tests++;
    if (e !== 1'b1 || rd !== 32'h0) begin
      fails++; $display("[TB] FAIL size_11: err=%b rd=%h want 1 0", e, rd);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, rd, e, lat);
    tests++;
    if (e !== 1'b1 || rd !== 32'h0 || lat !== cur_lat()) begin
      fails++; $display("[TB] FAIL lw_range: err=%b rd=%h lat=%0d want 1 0 %0d", e, rd, lat, cur_lat());
    end
    do_req(1'b1, 2'b10, 1'b0, 32'hFFC, 32'hCAFEF00D, rd, e, lat);
    do_req(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, rd, e, lat);
    tests++;
    if (e !== 1'b0 || rd !== 32'hCAFEF00D) begin
      fails++; $display("[TB] FAIL lw_top_word: err=%b rd=%h want 0 cafef00d", e, rd);
    end
  endtask

  task automatic test_back_to_back();
    int accepts[3];
    int na;
    int bad_ready;
    int guard;
    na = 0; bad_ready = 0;
    accepts = '{-100, -100, -100};
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid && ready) bad_ready++;
      if (ready && na < 3) begin
        accepts[na] = i;
        na++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    guard = 0;
    while ((!ready || rsp_valid) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (accepts[1] - accepts[0] !== cur_lat() + 1 || accepts[2] - accepts[1] !== cur_lat() + 1) begin
      fails++; $display("[TB] FAIL b2b_spacing sel=%0b: got %0d,%0d want %0d", sel,
                        accepts[1] - accepts[0], accepts[2] - accepts[1], cur_lat() + 1);
    end
    tests++;
    if (bad_ready !== 0) begin
      fails++; $display("[TB] FAIL ready_in_resp sel=%0b: got %0d cycles with ready high want 0", sel, bad_ready);
    end
  endtask

  task automatic test_wait_stable();
    logic [31:0] rd; logic e; int lat; int guard;
    guard = 0;
    @(negedge clk);
    while (!ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr = 32'h40;
    tests++;
    if (ready !== 1'b0) begin
      fails++; $display("[TB] FAIL ready_in_wait: got %b want 0", ready);
    end
    lat = 0; rd = 32'h0; e = 1'b0;
    for (int n = 2; n <= 20; n++) begin
      if (rsp_valid) begin
        lat = n - 1; rd = rsp_rdata; e = rsp_err;
        break;
      end
      @(negedge clk);
    end
    if (lat == 0 && rsp_valid) begin
      lat = 20; rd = rsp_rdata; e = rsp_err;
    end
    tests++;
    if (rd !== 32'hDEAD7FEF || e !== 1'b0 || lat !== 2) begin
      fails++; $display("[TB] FAIL addr_change_in_wait: rd=%h err=%b lat=%0d want dead7fef 0 2", rd, e, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic e; int lat; int seen;
    seen = 0;
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hA5A5A5A5, rd, e, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h20;
    req_wdata = 32'h12345678;
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++; $display("[TB] FAIL reset_mid_valid: got %0d pulses want 0", seen);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, e, lat);
    tests++;
    if (rd !== 32'hA5A5A5A5 || e !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_mid_mem: rd=%h err=%b want a5a5a5a5 0", rd, e);
    end
  endtask

  initial begin
    sel = 1'b0;
    test_reset();
    test_store_load();
    test_byte_store();
    test_half_load();
    test_errors();
    test_back_to_back();
    test_wait_stable();
    test_reset_mid();
    sel = 1'b1;
    @(negedge clk);
    test_store_load();
    test_byte_store();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
